// File: rtl/kb_bcd_calc_ctrl.sv
// Purpose: keyboard calculator controller; builds two BCD operands and an operator from key events, computes +,-,x and shows a signed BCD result.
// Latency: result_valid fires 2*DIGITS+1+BW cycles after the accepted Enter (CVT, OP, then double-dabble).
// Backpressure: none; keys arriving while busy (Esc included) are dropped, display holds its last value.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   key_valid         one-cycle strobe per make/break event
//   last_change       9-bit scancode of the event, bit 8 = E0 prefix
//   key_make          1 = press (only presses are acted on)
//   disp_bcd          RES_DIGITS BCD digits, digit 0 in [3:0]
//   disp_neg          displayed result is negative
//   busy              high through conversion, operation and double-dabble
//   result_valid      one-cycle pulse when a fresh result is loaded
//   state_dbg         current FSM state encoding
module kb_bcd_calc_ctrl #(
    parameter int DIGITS     = 2,
    parameter int RES_DIGITS = 2*DIGITS,
    parameter int BW         = 7*DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [8:0]              last_change,
    input  logic                    key_make,
    output logic [4*RES_DIGITS-1:0] disp_bcd,
    output logic                    disp_neg,
    output logic                    busy,
    output logic                    result_valid,
    output logic [2:0]              state_dbg
);
    localparam int AW = 4*DIGITS;
    localparam int RW = 4*RES_DIGITS;
    localparam int CW = 3;
    localparam int YW = 5;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);
    localparam logic [YW-1:0] CVT_LAST = YW'(2*DIGITS-1);
    localparam logic [YW-1:0] DD_LAST  = YW'(BW-1);

    typedef enum logic [2:0] {
        ENT_A = 3'd0,
        ENT_B = 3'd1,
        CVT   = 3'd2,
        OP    = 3'd3,
        DD    = 3'd4,
        SHOW  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_DIG  = 3'd1,
        K_OP   = 3'd2,
        K_ENT  = 3'd3,
        K_ESC  = 3'd4,
        K_BSP  = 3'd5
    } kind_t;

    state_t          state;
    op_t             op;
    logic [AW-1:0]   a_bcd, b_bcd;
    logic [CW-1:0]   cnt_a, cnt_b;
    logic [2*AW-1:0] cvt_sr;
    logic [BW-1:0]   acc_a, acc_b, res_bin;
    logic            res_neg;
    logic [RW-1:0]   dd_bcd;
    logic [YW-1:0]   cyc;

    // Key classification; break events never produce a kind.
    kind_t      kind;
    logic [3:0] kdig;
    op_t        kop;

    always_comb begin
        kind = K_NONE;
        kdig = 4'd0;
        kop  = OP_ADD;
        if (key_valid && key_make) begin
            case (last_change)
                9'h045, 9'h070: begin kind = K_DIG; kdig = 4'd0; end
                9'h016, 9'h069: begin kind = K_DIG; kdig = 4'd1; end
                9'h01E, 9'h072: begin kind = K_DIG; kdig = 4'd2; end
                9'h026, 9'h07A: begin kind = K_DIG; kdig = 4'd3; end
                9'h025, 9'h06B: begin kind = K_DIG; kdig = 4'd4; end
                9'h02E, 9'h073: begin kind = K_DIG; kdig = 4'd5; end
                9'h036, 9'h074: begin kind = K_DIG; kdig = 4'd6; end
                9'h03D, 9'h06C: begin kind = K_DIG; kdig = 4'd7; end
                9'h03E, 9'h075: begin kind = K_DIG; kdig = 4'd8; end
                9'h046, 9'h07D: begin kind = K_DIG; kdig = 4'd9; end
                9'h079:         begin kind = K_OP;  kop  = OP_ADD; end
                9'h07B:         begin kind = K_OP;  kop  = OP_SUB; end
                9'h07C:         begin kind = K_OP;  kop  = OP_MUL; end
                9'h05A, 9'h15A: kind = K_ENT;
                9'h076:         kind = K_ESC;
                9'h066:         kind = K_BSP;
                default:        kind = K_NONE;
            endcase
        end
    end

    // Operand edit values: push a digit in at the LSD, or drop the LSD.
    logic [AW-1:0] a_push, a_pop, b_push, b_pop;
    always_comb begin
        a_push = (a_bcd << 4) | AW'(kdig);
        a_pop  = a_bcd >> 4;
        b_push = (b_bcd << 4) | AW'(kdig);
        b_pop  = b_bcd >> 4;
    end

    // BCD->binary step: the top nibble of {A,B} feeds acc*10+digit,
    // A for the first DIGITS cycles, B for the rest.
    logic [3:0]    cvt_dig;
    logic [BW-1:0] cvt_src, cvt_acc;
    always_comb begin
        cvt_dig = cvt_sr[2*AW-1 -: 4];
        cvt_src = (cyc < YW'(DIGITS)) ? acc_a : acc_b;
        cvt_acc = (cvt_src << 3) + (cvt_src << 1) + BW'(cvt_dig);
    end

    // Double-dabble step: correct nibbles >=5, then shift {bcd, bin} left.
    logic [RW-1:0]    dd_adj;
    logic [RW+BW-1:0] dd_shift;
    always_comb begin
        dd_adj = dd_bcd;
        for (int i = 0; i < RES_DIGITS; i++) begin
            if (dd_bcd[4*i +: 4] >= 4'd5)
                dd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
        end
        dd_shift = {dd_adj, res_bin} << 1;
    end

    // Esc only acts in the idle states; during busy it is dropped.
    logic do_clear;
    always_comb begin
        do_clear = (kind == K_ESC) &&
                   ((state == ENT_A) || (state == ENT_B) || (state == SHOW));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ENT_A;
            op           <= OP_ADD;
            a_bcd        <= '0;
            b_bcd        <= '0;
            cnt_a        <= '0;
            cnt_b        <= '0;
            cvt_sr       <= '0;
            acc_a        <= '0;
            acc_b        <= '0;
            res_bin      <= '0;
            res_neg      <= 1'b0;
            dd_bcd       <= '0;
            cyc          <= '0;
            disp_bcd     <= '0;
            disp_neg     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (do_clear) begin
                state    <= ENT_A;
                op       <= OP_ADD;
                a_bcd    <= '0;
                b_bcd    <= '0;
                cnt_a    <= '0;
                cnt_b    <= '0;
                disp_bcd <= '0;
                disp_neg <= 1'b0;
            end else begin
                case (state)
                    ENT_A: begin
                        case (kind)
                            K_DIG: if (cnt_a < CNT_MAX) begin
                                a_bcd    <= a_push;
                                cnt_a    <= cnt_a + CW'(1);
                                disp_bcd <= RW'(a_push);
                            end
                            K_BSP: if (cnt_a != '0) begin
                                a_bcd    <= a_pop;
                                cnt_a    <= cnt_a - CW'(1);
                                disp_bcd <= RW'(a_pop);
                            end
                            K_OP: begin
                                op       <= kop;
                                state    <= ENT_B;
                                disp_bcd <= RW'(b_bcd);
                            end
                            default: ;
                        endcase
                    end
                    ENT_B: begin
                        case (kind)
                            K_DIG: if (cnt_b < CNT_MAX) begin
                                b_bcd    <= b_push;
                                cnt_b    <= cnt_b + CW'(1);
                                disp_bcd <= RW'(b_push);
                            end
                            K_BSP: if (cnt_b != '0) begin
                                b_bcd    <= b_pop;
                                cnt_b    <= cnt_b - CW'(1);
                                disp_bcd <= RW'(b_pop);
                            end
                            // The operator can still be changed until B has a digit.
                            K_OP: if (cnt_b == '0) op <= kop;
                            K_ENT: begin
                                state  <= CVT;
                                busy   <= 1'b1;
                                cvt_sr <= {a_bcd, b_bcd};
                                acc_a  <= '0;
                                acc_b  <= '0;
                                cyc    <= '0;
                            end
                            default: ;
                        endcase
                    end
                    CVT: begin
                        if (cyc < YW'(DIGITS)) acc_a <= cvt_acc;
                        else                   acc_b <= cvt_acc;
                        cvt_sr <= cvt_sr << 4;
                        if (cyc == CVT_LAST) state <= OP;
                        else                 cyc   <= cyc + YW'(1);
                    end
                    OP: begin
                        res_neg <= 1'b0;
                        case (op)
                            OP_SUB: begin
                                if (acc_a >= acc_b) begin
                                    res_bin <= acc_a - acc_b;
                                end else begin
                                    res_bin <= acc_b - acc_a;
                                    res_neg <= 1'b1;
                                end
                            end
                            OP_MUL:  res_bin <= acc_a * acc_b;
                            default: res_bin <= acc_a + acc_b;
                        endcase
                        dd_bcd <= '0;
                        cyc    <= '0;
                        state  <= DD;
                    end
                    DD: begin
                        dd_bcd  <= dd_shift[RW+BW-1:BW];
                        res_bin <= dd_shift[BW-1:0];
                        cyc     <= cyc + YW'(1);
                        if (cyc == DD_LAST) begin
                            state        <= SHOW;
                            busy         <= 1'b0;
                            disp_bcd     <= dd_shift[RW+BW-1:BW];
                            disp_neg     <= res_neg;
                            result_valid <= 1'b1;
                        end
                    end
                    SHOW: begin
                        // A digit starts a fresh calculation with that digit as A.
                        if (kind == K_DIG) begin
                            a_bcd    <= AW'(kdig);
                            cnt_a    <= CW'(1);
                            b_bcd    <= '0;
                            cnt_b    <= '0;
                            disp_bcd <= RW'(kdig);
                            disp_neg <= 1'b0;
                            state    <= ENT_A;
                        end
                    end
                    default: state <= ENT_A;
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/kb_bcd_calc_ctrl.md
Name: kb_bcd_calc_ctrl

Overview:
- Keyboard-driven calculator controller for the PS/2 keyboard → seven-segment path.
- Consumes decoded key events from KeyboardDecoder.
- Collects two decimal operands of up to DIGITS digits and an operator (+, −, ×).
- Computes the result, converts it to BCD sequentially (double-dabble), and presents signed BCD digits to the ssd scan block.

Parameters:
- DIGITS, 2, maximum decimal digits per operand (1..4).
- RES_DIGITS, 2*DIGITS, result BCD digits presented; derived, do not override.
- BW, 7*DIGITS, binary datapath width; derived. 2^(7D) exceeds 10^(2D).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- key_valid  input  1  one-cycle strobe from KeyboardDecoder, on both make and break
- last_change  input  9  scancode of the event; bit 8 = E0-extended
- key_make  input  1  key_down[last_change], sampled with key_valid; 1 = press
- disp_bcd  output  4*RES_DIGITS  BCD digits, digit 0 in bits [3:0]
- disp_neg  output  1  result is negative
- busy  output  1  computation in progress
- result_valid  output  1  one-cycle pulse when disp_bcd holds a fresh result
- state_dbg  output  3  current FSM state encoding

Behaviour:
- Key event definition:
  - Only key_valid=1 with key_make=1 is an event. Break events are ignored.
- Accepted key codes:
  - Digits, top row: 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46 → 0..9.
  - Digits, keypad: 0x70, 0x69, 0x72, 0x7A, 0x6B, 0x73, 0x74, 0x6C, 0x75, 0x7D → 0..9.
  - Operators: 0x79 = add, 0x7B = sub, 0x7C = mul.
  - Enter: 0x05A or 0x15A. Esc: 0x076. Backspace: 0x066.
  - All other codes are ignored.
- Reset (rst=0, asynchronous):
  - state=ENT_A; operands, digit counters and operator cleared.
  - disp_bcd=0, disp_neg=0, busy=0, result_valid=0.
- State ENT_A (000):
  - Digit: if cntA<DIGITS, A_bcd←{A_bcd<<4, d} and cntA++. Otherwise ignored.
  - Backspace: if cntA>0, A_bcd>>4 and cntA−−.
  - Operator: latch op, go to ENT_B. Works with cntA=0, in which case A=0.
  - Enter: ignored.
  - disp_bcd = A_bcd zero-extended; disp_neg=0.
- State ENT_B (001):
  - Digit and Backspace act on B as in ENT_A.
  - Operator with cntB=0: replaces op. Operator with cntB>0: ignored.
  - Enter: go to CVT. With cntB=0, B=0.
  - disp_bcd = B_bcd.
- State CVT (010), BCD→binary:
  - Lasts 2*DIGITS cycles.
  - One digit per cycle, A first, then B, MSD first: acc←acc*10+digit.
- State OP (011), 1 cycle:
  - add: R=A+B.
  - sub: if A≥B then R=A−B, neg=0; else R=B−A, neg=1.
  - mul: R=A*B.
  - All arithmetic is BW-bit unsigned. Overflow is impossible by construction.
- State DD (100), double-dabble:
  - Exactly BW cycles.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift left by 1, bringing in the R MSB.
- State SHOW (101):
  - Entered after the last DD cycle.
  - On the same clock edge, disp_bcd and disp_neg are loaded and result_valid pulses high for 1 cycle.
  - Display is held.
  - Digit key: clears A, B and counters, goes to ENT_A, and applies the digit as the first A digit.
  - Operator, Enter and Backspace: ignored.
- busy:
  - High in CVT, OP and DD.
  - Exactly 2*DIGITS+1+BW cycles, starting on the clock after the accepted Enter.
- During busy:
  - All keys are ignored, including Esc.
  - disp_bcd keeps its last value.
- Esc in ENT_A, ENT_B or SHOW:
  - Synchronous clear to the reset state; result_valid not pulsed.
- Simultaneous events:
  - Only one key_valid per cycle is possible; no arbitration is required.
  - A key_valid arriving on the cycle busy falls is processed in SHOW.
- disp_bcd leading zeros are not blanked; blanking belongs to ssd.

Test Plan:
- DIGITS=2: keys 1,2,+,3,4,Enter → busy high exactly 19 cycles, then result_valid pulse; disp_bcd=0x0046, disp_neg=0.
- Keys 5,−,3,7,KP-Enter(0x15A) → disp_bcd=0x0032, disp_neg=1. Then key 8 → ENT_A, disp_bcd=0x0008.
- Keys 9,9,*,9,9,Enter → disp_bcd=0x9801. Then 0,*,7,Enter → 0x0000, disp_neg=0.
- Keys 1,2,3 → disp_bcd=0x0012, third digit dropped. Backspace → 0x0001. Break-code strobes (key_make=0) interleaved → no change.
- Keys 4,+,−,6,Enter → op=sub applied, disp_bcd=0x0002, disp_neg=1. Esc in ENT_B → all outputs 0, state_dbg=000.
- rst low for 1 cycle mid-DD → busy=0, disp_bcd=0, state ENT_A, no result_valid. Esc during busy → ignored, result still produced.
